// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared pipeline constants and hazard-sequencer state encoding
package mips_pkg;
   typedef enum logic [1:0] {
      RUN     = 2'd0,
      MULDIV  = 2'd1,
      MEMWAIT = 2'd2
   } hz_state_t;

   localparam logic [4:0]  REG_ZERO  = 5'd0;
   localparam logic [31:0] NOP_INSTR = 32'h00000000;

   function automatic logic load_use_hit(input logic       mem_read,
                                         input logic [4:0] ex_rt,
                                         input logic [4:0] id_rs,
                                         input logic [4:0] id_rt);
      return mem_read && (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
   endfunction
endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter used for pipeline performance statistics
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (inc && (count != {W{1'b1}})) begin
         count <= count + 1'b1;
      end
   end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// rtl/pipeline_hazard_controller.sv - stall/flush sequencer for the 5-stage pipeline front end
module pipeline_hazard_controller
   import mips_pkg::*;
#(
   parameter int MULDIV_CYCLES = 32,
   parameter int CNT_W         = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       IF_ID_Rs,
   input  logic [4:0]       IF_ID_Rt,
   input  logic [4:0]       ID_EX_Rt,
   input  logic             ID_EX_MemRead,
   input  logic             ID_MulDiv,
   input  logic             Branch_Control,
   input  logic             Mem_Busy,
   output logic             PC_Write,
   output logic             IF_ID_enable,
   output logic             IF_ID_flush,
   output logic             ID_EX_bubble,
   output logic             Pipe_Hold,
   output logic [CNT_W-1:0] Stall_Cnt,
   output logic [CNT_W-1:0] Flush_Cnt
);
   localparam int              MD_W    = (MULDIV_CYCLES > 2) ? $clog2(MULDIV_CYCLES) : 1;
   localparam logic [MD_W-1:0] MD_LOAD = MD_W'(MULDIV_CYCLES - 2);

   hz_state_t       state, state_nx, eff_state;
   logic [MD_W-1:0] mdcnt, mdcnt_nx;
   logic            ret_md, ret_md_nx;
   logic            load_use;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= RUN;
         mdcnt  <= '0;
         ret_md <= 1'b0;
      end else begin
         state  <= state_nx;
         mdcnt  <= mdcnt_nx;
         ret_md <= ret_md_nx;
      end
   end

   assign load_use = load_use_hit(ID_EX_MemRead, ID_EX_Rt, IF_ID_Rs, IF_ID_Rt);

   // On the cycle memory becomes ready, MEMWAIT behaves exactly like the state it interrupted.
   always_comb begin
      PC_Write     = 1'b1;
      IF_ID_enable = 1'b1;
      IF_ID_flush  = 1'b0;
      ID_EX_bubble = 1'b0;
      Pipe_Hold    = 1'b0;
      state_nx     = state;
      mdcnt_nx     = mdcnt;
      ret_md_nx    = ret_md;
      eff_state    = state;
      if (state == MEMWAIT) begin
         eff_state = ret_md ? MULDIV : RUN;
      end

      if (Mem_Busy) begin
         PC_Write     = 1'b0;
         IF_ID_enable = 1'b0;
         Pipe_Hold    = 1'b1;
         state_nx     = MEMWAIT;
         ret_md_nx    = (eff_state == MULDIV);
      end else begin
         case (eff_state)
            MULDIV: begin
               PC_Write     = 1'b0;
               IF_ID_enable = 1'b0;
               ID_EX_bubble = 1'b1;
               if (mdcnt == '0) begin
                  state_nx = RUN;
               end else begin
                  state_nx = MULDIV;
                  mdcnt_nx = mdcnt - 1'b1;
               end
            end
            default: begin
               state_nx = RUN;
               if (Branch_Control) begin
                  IF_ID_flush  = 1'b1;
                  ID_EX_bubble = 1'b1;
               end else if (load_use) begin
                  PC_Write     = 1'b0;
                  IF_ID_enable = 1'b0;
                  ID_EX_bubble = 1'b1;
               end else if (ID_MulDiv) begin
                  state_nx = MULDIV;
                  mdcnt_nx = MD_LOAD;
               end
            end
         endcase
      end
   end

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (~IF_ID_enable),
      .count (Stall_Cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (IF_ID_flush),
      .count (Flush_Cnt)
   );
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// tb/tb_pipeline_hazard_controller.sv - directed scoreboard bench for pipeline_hazard_controller
module tb_pipeline_hazard_controller;
   localparam int MDC   = 4;
   localparam int CW    = 4;
   localparam int MAXC  = (1 << CW) - 1;

   localparam logic [4:0] E_RUN   = 5'b11000;
   localparam logic [4:0] E_STALL = 5'b00010;
   localparam logic [4:0] E_FLUSH = 5'b11110;
   localparam logic [4:0] E_HOLD  = 5'b00001;

   logic          clk = 1'b0;
   logic          reset;
   logic [4:0]    IF_ID_Rs, IF_ID_Rt, ID_EX_Rt;
   logic          ID_EX_MemRead, ID_MulDiv, Branch_Control, Mem_Busy;
   logic          PC_Write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, Pipe_Hold;
   logic [CW-1:0] Stall_Cnt, Flush_Cnt;

   typedef struct {
      logic [4:0] v;
      string      tag;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   stall_m = 0;
   int   flush_m = 0;

   pipeline_hazard_controller #(.MULDIV_CYCLES(MDC), .CNT_W(CW)) dut (
      .clk            (clk),
      .reset          (reset),
      .IF_ID_Rs       (IF_ID_Rs),
      .IF_ID_Rt       (IF_ID_Rt),
      .ID_EX_Rt       (ID_EX_Rt),
      .ID_EX_MemRead  (ID_EX_MemRead),
      .ID_MulDiv      (ID_MulDiv),
      .Branch_Control (Branch_Control),
      .Mem_Busy       (Mem_Busy),
      .PC_Write       (PC_Write),
      .IF_ID_enable   (IF_ID_enable),
      .IF_ID_flush    (IF_ID_flush),
      .ID_EX_bubble   (ID_EX_bubble),
      .Pipe_Hold      (Pipe_Hold),
      .Stall_Cnt      (Stall_Cnt),
      .Flush_Cnt      (Flush_Cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Outputs packed as {PC_Write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, Pipe_Hold}.
   task automatic compare_front();
      exp_t x;
      x = sb.pop_front();
      chk(x.tag, {11'd0, PC_Write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, Pipe_Hold}, {11'd0, x.v});
      chk({x.tag, "_stall_cnt"}, 16'(Stall_Cnt), 16'(stall_m));
      chk({x.tag, "_flush_cnt"}, 16'(Flush_Cnt), 16'(flush_m));
   endtask

   task automatic apply(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] ex_rt,
                        input logic mr, input logic md, input logic br, input logic mb,
                        input logic [4:0] e, input string tag);
      exp_t x;
      @(negedge clk);
      IF_ID_Rs       = rs;
      IF_ID_Rt       = rt;
      ID_EX_Rt       = ex_rt;
      ID_EX_MemRead  = mr;
      ID_MulDiv      = md;
      Branch_Control = br;
      Mem_Busy       = mb;
      x.v   = e;
      x.tag = tag;
      sb.push_back(x);
      #2 compare_front();
      @(posedge clk);
      if (!e[3] && stall_m != MAXC) stall_m++;
      if (e[2] && flush_m != MAXC) flush_m++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      reset          = 1'b0;
      IF_ID_Rs       = '0;
      IF_ID_Rt       = '0;
      ID_EX_Rt       = '0;
      ID_EX_MemRead  = 1'b0;
      ID_MulDiv      = 1'b0;
      Branch_Control = 1'b0;
      Mem_Busy       = 1'b0;

      #12;
      chk("reset_outputs", {11'd0, PC_Write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, Pipe_Hold}, {11'd0, E_RUN});
      chk("reset_stall_cnt", 16'(Stall_Cnt), 16'd0);
      chk("reset_flush_cnt", 16'(Flush_Cnt), 16'd0);
      #10 reset = 1'b1;

      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "post_reset");
      apply(5'd8, 5'd3, 5'd8, 1, 0, 0, 0, E_STALL, "loaduse_rs");
      apply(5'd0, 5'd3, 5'd0, 1, 0, 0, 0, E_RUN,   "loaduse_r0");
      chk("stall_after_loaduse", 16'(Stall_Cnt), 16'd1);
      apply(5'd4, 5'd9, 5'd9, 1, 0, 0, 0, E_STALL, "loaduse_rt");
      apply(5'd9, 5'd9, 5'd9, 0, 0, 0, 0, E_RUN,   "no_memread");

      apply(5'd8, 5'd3, 5'd8, 1, 0, 1, 0, E_FLUSH, "branch_over_loaduse");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "after_branch");
      chk("flush_after_branch", 16'(Flush_Cnt), 16'd1);
      chk("stall_after_branch", 16'(Stall_Cnt), 16'd2);

      apply(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_RUN,   "muldiv_issue");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STALL, "muldiv_f1");
      apply(5'd8, 5'd0, 5'd8, 1, 0, 1, 0, E_STALL, "muldiv_f2_branch_ign");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STALL, "muldiv_f3");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "muldiv_done");

      apply(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_RUN,   "md2_issue");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STALL, "md2_f1");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_HOLD,  "md2_memwait1");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 1, E_HOLD,  "md2_memwait2");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STALL, "md2_f2");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STALL, "md2_f3");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "md2_done");

      apply(5'd8, 5'd0, 5'd8, 1, 0, 1, 1, E_HOLD,  "run_memwait");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "run_memwait_exit");

      apply(5'd0, 5'd0, 5'd0, 0, 1, 0, 0, E_RUN,   "md3_issue");
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_STALL, "md3_f1");
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      stall_m = 0;
      flush_m = 0;
      chk("async_reset_outputs", {11'd0, PC_Write, IF_ID_enable, IF_ID_flush, ID_EX_bubble, Pipe_Hold}, {11'd0, E_RUN});
      chk("async_reset_stall_cnt", 16'(Stall_Cnt), 16'd0);
      chk("async_reset_flush_cnt", 16'(Flush_Cnt), 16'd0);
      @(posedge clk);
      #2 reset = 1'b1;
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "after_async_reset");

      for (int i = 0; i < 20; i++) begin
         apply(5'd8, 5'd0, 5'd8, 1, 0, 0, 0, E_STALL, "sat_stall");
      end
      apply(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, E_RUN,   "sat_end");
      chk("sat_final", 16'(Stall_Cnt), 16'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
